// File: rtl/buzzer_sequencer_if.sv
// Request/playback bundle between requesters and the buzzer sequencer.
// master = requester side, slave = sequencer side.
interface buzzer_sequencer_if;
    logic [2:0]  req;
    logic        abort;
    logic [31:0] freq;
    logic        tone_en;
    logic [2:0]  grant;
    logic        busy;
    logic        done;

    modport master (
        output req, abort,
        input  freq, tone_en, grant, busy, done
    );

    modport slave (
        input  req, abort,
        output freq, tone_en, grant, busy, done
    );
endinterface

// File: rtl/buzzer_sequencer.sv
// Buzzer pattern sequencer: arbitrates three requesters and steps
// through the note ROM, driving frequency/duration to a tone generator.
module buzzer_sequencer #(
    parameter int MS_CYCLES = 50000,
    parameter int GAP_MS    = 50
) (
    input  logic clk,
    input  logic rst,
    buzzer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE
    } state_t;

    localparam logic [31:0] MS      = 32'(MS_CYCLES);
    localparam logic [31:0] GAP_CYC = 32'(GAP_MS) * MS;

    state_t      r_state, w_next;
    logic [2:0]  r_pend,  w_pend;
    logic [1:0]  r_sel,   w_sel;
    logic [1:0]  r_idx,   w_idx;
    logic [31:0] r_cnt,   w_cnt;
    logic [2:0]  w_any;
    logic        w_last;

    logic [31:0] r_freq,  w_freq;
    logic        r_tone,  w_tone;
    logic [2:0]  r_grant, w_grant;
    logic        r_busy,  w_busy;
    logic        r_done,  w_done;

    function automatic logic [31:0] rom_freq(input logic [1:0] p,
                                             input logic [1:0] n);
        case ({p, n})
            4'b00_00: rom_freq = 32'd2000;
            4'b01_00: rom_freq = 32'd523;
            4'b01_01: rom_freq = 32'd659;
            4'b01_10: rom_freq = 32'd784;
            4'b10_00: rom_freq = 32'd200;
            4'b10_01: rom_freq = 32'd200;
            default:  rom_freq = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rom_ms(input logic [1:0] p,
                                           input logic [1:0] n);
        case ({p, n})
            4'b00_00: rom_ms = 32'd30;
            4'b01_00: rom_ms = 32'd150;
            4'b01_01: rom_ms = 32'd150;
            4'b01_10: rom_ms = 32'd150;
            4'b10_00: rom_ms = 32'd300;
            4'b10_01: rom_ms = 32'd300;
            default:  rom_ms = 32'd1;
        endcase
    endfunction

    function automatic logic [1:0] rom_last(input logic [1:0] p);
        case (p)
            2'd1:    rom_last = 2'd2;
            2'd2:    rom_last = 2'd1;
            default: rom_last = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] sel_oh(input logic [1:0] p);
        sel_oh = 3'b001 << p;
    endfunction

    assign w_any  = bus.req | r_pend;
    assign w_last = (r_idx == rom_last(r_sel));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; abort wins over everything
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (|w_any) w_next = S_LOAD;
                S_LOAD: w_next = S_PLAY;
                S_PLAY: if (r_cnt == 32'd0)
                            w_next = w_last ? S_DONE : S_GAP;
                S_GAP:  if (r_cnt == 32'd0) w_next = S_PLAY;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Selection, pending requests, note index and duration counter
    always_comb begin
        w_pend = r_pend;
        w_sel  = r_sel;
        w_idx  = r_idx;
        w_cnt  = r_cnt;
        if (bus.abort) begin
            w_pend = 3'b000;
            w_idx  = 2'd0;
            w_cnt  = 32'd0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_any[2])      w_sel = 2'd2;
                else if (w_any[1]) w_sel = 2'd1;
                else if (w_any[0]) w_sel = 2'd0;
                w_pend = w_any & ~sel_oh(w_sel);
            end else begin
                w_pend = r_pend | bus.req;
            end
            if (r_state == S_LOAD)
                w_idx = 2'd0;
            if (r_state == S_GAP && w_next == S_PLAY)
                w_idx = r_idx + 2'd1;
            if (w_next == S_PLAY && r_state != S_PLAY)
                w_cnt = rom_ms(w_sel, w_idx) * MS - 32'd1;
            else if (w_next == S_GAP && r_state != S_GAP)
                w_cnt = GAP_CYC - 32'd1;
            else if (r_cnt != 32'd0 &&
                     (r_state == S_PLAY || r_state == S_GAP))
                w_cnt = r_cnt - 32'd1;
        end
    end

    // Output decode from the state being entered, so outputs register cleanly
    always_comb begin
        w_freq  = 32'd0;
        w_tone  = 1'b0;
        w_grant = 3'b000;
        w_busy  = (w_next != S_IDLE);
        w_done  = (w_next == S_DONE);
        if (w_next != S_IDLE)
            w_grant = sel_oh(w_sel);
        if (w_next == S_PLAY) begin
            w_freq = rom_freq(w_sel, w_idx);
            w_tone = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= 3'b000;
            r_sel   <= 2'd0;
            r_idx   <= 2'd0;
            r_cnt   <= 32'd0;
            r_freq  <= 32'd0;
            r_tone  <= 1'b0;
            r_grant <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pend  <= w_pend;
            r_sel   <= w_sel;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_freq  <= w_freq;
            r_tone  <= w_tone;
            r_grant <= w_grant;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign bus.freq    = r_freq;
    assign bus.tone_en = r_tone;
    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: expected output segments (tuple + length)
// are queued by the stimulus and checked by an independent monitor.
module tb_buzzer_sequencer;
    logic clk;
    logic rst;

    buzzer_sequencer_if bus();

    buzzer_sequencer #(
        .MS_CYCLES(2),
        .GAP_MS(5)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [37:0] t;
        int          len;
    } seg_t;

    seg_t        sb[$];
    int          checks;
    int          errors;
    bit          mon_en;
    bit          have;
    logic [37:0] run_t;
    int          run_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tuple = {freq, tone_en, grant, busy, done}
    function automatic logic [37:0] cur();
        return {bus.freq, bus.tone_en, bus.grant, bus.busy, bus.done};
    endfunction

    task automatic push(input logic [31:0] f, input logic tn,
                        input logic [2:0] g, input logic b,
                        input logic d, input int len);
        seg_t s;
        s.t   = {f, tn, g, b, d};
        s.len = len;
        sb.push_back(s);
    endtask

    // Hand-computed pattern timings for MS_CYCLES=2, GAP_MS=5
    task automatic exp_pat(input int p, input int idle_len);
        logic [2:0] g;
        g = 3'b001 << p;
        push(0, 0, g, 1, 0, 1);
        case (p)
            0: push(2000, 1, g, 1, 0, 60);
            1: begin
                push(523, 1, g, 1, 0, 300);
                push(0,   0, g, 1, 0, 10);
                push(659, 1, g, 1, 0, 300);
                push(0,   0, g, 1, 0, 10);
                push(784, 1, g, 1, 0, 300);
            end
            default: begin
                push(200, 1, g, 1, 0, 600);
                push(0,   0, g, 1, 0, 10);
                push(200, 1, g, 1, 0, 600);
            end
        endcase
        push(0, 0, g, 1, 1, 1);
        push(0, 0, 3'b000, 0, 0, idle_len);
    endtask

    // Monitor: close a segment whenever the output tuple changes
    always @(negedge clk) begin
        if (mon_en) begin
            logic [37:0] t;
            seg_t e;
            t = cur();
            if (!have) begin
                have    = 1'b1;
                run_t   = t;
                run_len = 1;
            end else if (t === run_t) begin
                run_len = run_len + 1;
            end else begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL extra_seg got=%h len=%0d want=none",
                             run_t, run_len);
                end else begin
                    e = sb.pop_front();
                    if (run_t !== e.t ||
                        (e.len != 0 && run_len != e.len)) begin
                        errors = errors + 1;
                        $display("FAIL seg got=%h len=%0d want=%h len=%0d",
                                 run_t, run_len, e.t, e.len);
                    end
                end
                run_t   = t;
                run_len = 1;
            end
        end
    end

    task automatic pulse_req(input logic [2:0] r);
        @(posedge clk);
        #1 bus.req = r;
        @(posedge clk);
        #1 bus.req = 3'b000;
    endtask

    task automatic wait_quiet(input int max);
        int q;
        q = 0;
        for (int i = 0; i < max && q < 3; i++) begin
            @(negedge clk);
            q = bus.busy ? 0 : q + 1;
        end
        if (q < 3) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout busy=%b want=0", bus.busy);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mon_en  = 1'b0;
        have    = 1'b0;
        run_len = 0;
        rst     = 1'b1;
        bus.req   = 3'b000;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (cur() !== 38'd0) begin
            errors = errors + 1;
            $display("FAIL reset got=%h want=0", cur());
        end
        push(0, 0, 3'b000, 0, 0, 0);
        mon_en = 1'b1;

        // click
        exp_pat(0, 0);
        pulse_req(3'b001);
        wait_quiet(200);

        // success
        exp_pat(1, 0);
        pulse_req(3'b010);
        wait_quiet(1200);

        // all three at once: 2, then 1, then 0 with one idle cycle between
        exp_pat(2, 1);
        exp_pat(1, 1);
        exp_pat(0, 0);
        pulse_req(3'b111);
        wait_quiet(3000);

        // re-request of the playing pattern replays it once
        exp_pat(2, 1);
        exp_pat(2, 0);
        pulse_req(3'b100);
        repeat (100) @(posedge clk);
        pulse_req(3'b100);
        wait_quiet(3000);

        // abort during second note of success, with a click request
        push(0,   0, 3'b010, 1, 0, 1);
        push(523, 1, 3'b010, 1, 0, 300);
        push(0,   0, 3'b010, 1, 0, 10);
        push(659, 1, 3'b010, 1, 0, 10);
        push(0,   0, 3'b000, 0, 0, 0);
        pulse_req(3'b010);
        repeat (320) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        bus.req   = 3'b001;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.req   = 3'b000;
        repeat (100) @(posedge clk);

        // reset mid-gap with click pending
        push(0,   0, 3'b010, 1, 0, 1);
        push(523, 1, 3'b010, 1, 0, 300);
        push(0,   0, 3'b010, 1, 0, 4);
        push(0,   0, 3'b000, 0, 0, 0);
        pulse_req(3'b010);
        repeat (50) @(posedge clk);
        #1 bus.req = 3'b001;
        @(posedge clk);
        #1 bus.req = 3'b000;
        repeat (253) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;

        checks = checks + 1;
        if (sb.size() != 1 || run_t !== 38'd0) begin
            errors = errors + 1;
            $display("FAIL final_idle got=%0d/%h want=1/0",
                     sb.size(), run_t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
- Plays fixed multi-note sound patterns on one shared buzzer tone generator.
- Arbitrates three sound requesters and sequences note frequency and duration for the selected pattern.
- Drives the generator's 32-bit frequency input; freq = 0 means silence downstream.
- Sits between game/control logic (requesters) and the square-wave tone generator.

Parameters:
- MS_CYCLES, 50000: clock cycles per millisecond (50 MHz clock); bench uses 2.
- GAP_MS, 50: silence between consecutive notes of one pattern, in ms.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  3  request pulses or levels, one per pattern; bit 2 has highest priority.
- abort  in  1  stop playback immediately and drop everything pending.
- freq  out  32  tone frequency in Hz for the tone generator; 0 = silent.
- tone_en  out  1  high while a note is sounding.
- grant  out  3  one-hot index of the pattern being played; 0 when idle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pattern completes normally.

Behaviour:
- Pattern ROM is internal and constant. Note = (freq Hz, duration ms).
  - Pattern 0 "click": (2000, 30).
  - Pattern 1 "success": (523, 150), (659, 150), (784, 150).
  - Pattern 2 "error": (200, 300), (200, 300).
- Reset: state IDLE; freq = 0; tone_en, grant, busy, done = 0; pending = 0; all counters = 0.
- States:
  - IDLE: if (req | pending) is nonzero, select the highest set bit, clear that pending bit, go to LOAD.
  - LOAD: exactly 1 cycle. grant = selected one-hot, note index = 0, freq still 0, busy = 1. Next state is PLAY.
  - PLAY: freq = ROM freq, tone_en = 1.
    - Lasts exactly dur_ms × MS_CYCLES cycles.
    - At the end: if this is the last note, go to DONE; otherwise go to GAP.
  - GAP: freq = 0, tone_en = 0, for exactly GAP_MS × MS_CYCLES cycles. Then increment the note index and return to PLAY.
  - DONE: exactly 1 cycle. done = 1, freq = 0, grant still held. Next state is IDLE, where grant clears.
- Latency: request sampled in IDLE at edge N. LOAD occupies cycle N+1. First tone cycle is N+2.
- pending[2:0] is a sticky register.
  - Any req bit seen while busy sets the matching pending bit, including the bit currently playing, which makes the pattern replay afterwards.
  - Pending requests are served only from IDLE, by priority, one per visit to IDLE. There is no preemption.
  - IDLE lasts at least 1 cycle between patterns.
- Simultaneous requests in IDLE: the highest bit is granted. All other set bits go into pending in the same cycle.
- A req held high as a level re-requests continuously. Each completion is followed by a replay. This is intended.
- abort is honoured in any state and dominates req in the same cycle. Next cycle:
  - state IDLE; pending cleared; freq = 0; tone_en = 0; grant = 0.
  - No done pulse.
  - A req present in the abort cycle is ignored.
- rst mid-pattern has the same effect as abort. All counters also clear.
- Counters: duration counter is 32-bit. Arithmetic is unsigned. Counter reloads on every entry into PLAY or GAP. No overflow is possible for ROM values.
- All outputs are registered. freq changes only on state entry.

Test Plan:
- MS_CYCLES=2, GAP_MS=5. req=001 for 1 cycle in IDLE -> LOAD next cycle, then freq=2000 and tone_en=1 for exactly 60 cycles, then done=1 for 1 cycle with grant=001, then busy=0, freq=0.
- req=010 pulse -> freq 523 (300 cycles), 0 (10 cycles), 659 (300), 0 (10), 784 (300), then done; tone_en low during gaps.
- req=111 in the same cycle while idle -> pattern 2 plays (200 Hz ×2). Pattern 1 follows, then pattern 0. Each produces one done pulse, with 1 IDLE cycle plus LOAD between them.
- During pattern 2 first note, pulse req=100 -> pattern 2 finishes, then replays in full once. Exactly 2 done pulses.
- During pattern 1 second note, assert abort with req=001 in the same cycle -> next cycle freq=0, grant=0, busy=0, no done, and click never plays.
- rst asserted for 1 cycle mid-GAP with pending=001 -> all outputs 0, pending cleared, block stays idle with no further requests.
